// File: rtl/l2_bus_arbiter_if.sv
// l2_bus_arbiter_if: I/D master ports and the L2 cache bus bundled for the arbiter.
interface l2_bus_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] i_addr;
    logic              i_start;
    logic [DATA_W-1:0] i_q;
    logic              i_done;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data;
    logic              d_we;
    logic              d_start;
    logic [DATA_W-1:0] d_q;
    logic              d_done;
    logic [ADDR_W-1:0] l2_addr;
    logic [DATA_W-1:0] l2_data;
    logic              l2_we;
    logic              l2_start;
    logic [DATA_W-1:0] l2_q;
    logic              l2_done;
    modport slave (
        input  i_addr, i_start, d_addr, d_data, d_we, d_start, l2_q, l2_done,
        output i_q, i_done, d_q, d_done, l2_addr, l2_data, l2_we, l2_start
    );
    modport master (
        output i_addr, i_start, d_addr, d_data, d_we, d_start, l2_q, l2_done,
        input  i_q, i_done, d_q, d_done, l2_addr, l2_data, l2_we, l2_start
    );
endinterface

// File: rtl/l2_bus_arbiter.sv
// l2_bus_arbiter: round-robin I/D arbiter in front of the L2 cache bus.
// Each start assertion is served once, and l2_start always presents a clean rising edge.
module l2_bus_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input logic             clk,
    input logic             reset,
    l2_bus_arbiter_if.slave bus_io
);
    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
    state_t            state_q, state_d;
    logic              gnt_d_q, gnt_d_d, last_d_q, last_d_d;
    logic              i_arm_q, i_arm_d, d_arm_q, d_arm_d;
    logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
    logic [DATA_W-1:0] l2_data_q, l2_data_d, i_q_q, i_q_d, d_q_q, d_q_d;
    logic              l2_we_q, l2_we_d, l2_start_q, l2_start_d;
    logic              i_done_q, i_done_d, d_done_q, d_done_d;
    logic              i_el, d_el, pick_d;

    assign i_el   = bus_io.i_start & i_arm_q;
    assign d_el   = bus_io.d_start & d_arm_q;
    // On a tie, serve the port that did not win last time
    assign pick_d = d_el & (~i_el | ~last_d_q);

    always_comb begin
        state_d    = state_q;
        gnt_d_d    = gnt_d_q;
        last_d_d   = last_d_q;
        i_arm_d    = i_arm_q | ~bus_io.i_start;
        d_arm_d    = d_arm_q | ~bus_io.d_start;
        l2_addr_d  = l2_addr_q;
        l2_data_d  = l2_data_q;
        l2_we_d    = l2_we_q;
        l2_start_d = l2_start_q;
        i_q_d      = i_q_q;
        d_q_d      = d_q_q;
        i_done_d   = 1'b0;
        d_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                l2_start_d = i_el | d_el;
                l2_we_d    = (i_el | d_el) & pick_d & bus_io.d_we;
                if (i_el | d_el) begin
                    state_d   = ISSUE;
                    gnt_d_d   = pick_d;
                    last_d_d  = pick_d;
                    i_arm_d   = pick_d ? i_arm_d : 1'b0;
                    d_arm_d   = pick_d ? 1'b0 : d_arm_d;
                    l2_addr_d = pick_d ? bus_io.d_addr : bus_io.i_addr;
                    l2_data_d = pick_d ? bus_io.d_data : '0;
                end
            end
            ISSUE: begin
                if (bus_io.l2_done) begin
                    state_d    = RELEASE;
                    i_done_d   = ~gnt_d_q;
                    d_done_d   = gnt_d_q;
                    i_q_d      = gnt_d_q ? i_q_q : bus_io.l2_q;
                    d_q_d      = gnt_d_q ? bus_io.l2_q : d_q_q;
                    l2_start_d = 1'b0;
                    l2_we_d    = 1'b0;
                end
            end
            RELEASE: state_d = bus_io.l2_done ? RELEASE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_d_q    <= 1'b0;
            last_d_q   <= 1'b1;
            i_arm_q    <= 1'b0;
            d_arm_q    <= 1'b0;
            l2_addr_q  <= '0;
            l2_data_q  <= '0;
            l2_we_q    <= 1'b0;
            l2_start_q <= 1'b0;
            i_q_q      <= '0;
            d_q_q      <= '0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_d_q    <= gnt_d_d;
            last_d_q   <= last_d_d;
            i_arm_q    <= i_arm_d;
            d_arm_q    <= d_arm_d;
            l2_addr_q  <= l2_addr_d;
            l2_data_q  <= l2_data_d;
            l2_we_q    <= l2_we_d;
            l2_start_q <= l2_start_d;
            i_q_q      <= i_q_d;
            d_q_q      <= d_q_d;
            i_done_q   <= i_done_d;
            d_done_q   <= d_done_d;
        end
    end

    assign bus_io.l2_addr  = l2_addr_q;
    assign bus_io.l2_data  = l2_data_q;
    assign bus_io.l2_we    = l2_we_q;
    assign bus_io.l2_start = l2_start_q;
    assign bus_io.i_q      = i_q_q;
    assign bus_io.d_q      = d_q_q;
    assign bus_io.i_done   = i_done_q;
    assign bus_io.d_done   = d_done_q;
endmodule

// File: tb/tb_l2_bus_arbiter.sv
// tb_l2_bus_arbiter: directed and randomized transactions checked against a round-robin,
// transaction-level reference of the I/D arbiter.
module tb_l2_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   miss = 0;
    bit   last_d = 1'b1;

    l2_bus_arbiter_if bus ();
    l2_bus_arbiter dut (.clk(clk), .reset(reset), .bus_io(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_l2_start"}, bus.l2_start, 0);
        chk({tag, "_l2_we"}, bus.l2_we, 0);
        chk({tag, "_l2_addr"}, bus.l2_addr, 0);
        chk({tag, "_l2_data"}, bus.l2_data, 0);
        chk({tag, "_i_q"}, bus.i_q, 0);
        chk({tag, "_d_q"}, bus.d_q, 0);
        chk({tag, "_dones"}, {bus.i_done, bus.d_done}, 0);
    endtask

    // One granted access, entered at the sample right after the grant edge
    task automatic serve(input bit pd, input logic [23:0] a, input logic [31:0] dat, input bit we,
                         input int lat, input int dl, input bit hold, input bit wd,
                         input logic [31:0] rq);
        chk("l2_start_rise", bus.l2_start, 1);
        chk("l2_addr", bus.l2_addr, a);
        chk("l2_data", bus.l2_data, pd ? dat : 32'h0);
        chk("l2_we", bus.l2_we, pd & we);
        last_d = pd;
        for (int k = 0; k < lat; k++) begin
            if (k == 0) begin
                if (pd) bus.d_addr = 24'($urandom); else bus.i_addr = 24'($urandom);
                if (wd) begin
                    if (pd) bus.d_start = 1'b0; else bus.i_start = 1'b0;
                end
            end
            tick();
            chk("l2_start_hold", bus.l2_start, 1);
            chk("l2_addr_hold", bus.l2_addr, a);
            chk("done_early", {bus.i_done, bus.d_done}, 0);
        end
        bus.l2_done = 1'b1;
        bus.l2_q = rq;
        tick();
        chk("l2_start_fall", bus.l2_start, 0);
        chk("l2_we_fall", bus.l2_we, 0);
        chk("done_pulse", {bus.i_done, bus.d_done}, pd ? 2'b01 : 2'b10);
        chk("q_latch", pd ? bus.d_q : bus.i_q, rq);
        if (!hold) begin
            if (pd) bus.d_start = 1'b0; else bus.i_start = 1'b0;
        end
        bus.l2_q = ~rq;
        if (dl == 2) begin
            tick();
            chk("release_hold", bus.l2_start, 0);
            chk("done_once", {bus.i_done, bus.d_done}, 0);
        end
        bus.l2_done = 1'b0;
        tick();
        chk("gap_low", bus.l2_start, 0);
        chk("done_once2", {bus.i_done, bus.d_done}, 0);
        chk("q_stable", pd ? bus.d_q : bus.i_q, rq);
    endtask

    // mode: 0 = I only, 1 = D only, 2 = both raised together
    task automatic trial(input int mode, input logic [23:0] ia, input logic [23:0] da,
                         input logic [31:0] dd, input bit we, input int lat, input int dl,
                         input bit hold, input bit wd, input int idle_n, input logic [31:0] rq);
        bit first_d;
        bus.i_addr = ia;
        bus.d_addr = da;
        bus.d_data = dd;
        bus.d_we = we;
        bus.i_start = (mode != 1);
        bus.d_start = (mode != 0);
        first_d = (mode == 1) || (mode == 2 && !last_d);
        tick();
        serve(first_d, first_d ? da : ia, dd, we, lat, dl, hold, wd, rq);
        if (mode == 2) begin
            tick();
            serve(!first_d, first_d ? ia : da, dd, we, lat, dl, hold, wd, $urandom);
        end
        for (int k = 0; k < idle_n; k++) begin
            tick();
            chk("no_reserve", bus.l2_start, 0);
        end
        bus.i_start = 1'b0;
        bus.d_start = 1'b0;
        tick();
    endtask

    initial begin
        bus.i_addr = '0;
        bus.i_start = 1'b0;
        bus.d_addr = '0;
        bus.d_data = '0;
        bus.d_we = 1'b0;
        bus.d_start = 1'b0;
        bus.l2_q = 32'h5555AAAA;
        bus.l2_done = 1'b0;
        repeat (3) tick();
        all_zero("reset");
        reset = 1'b0;
        tick();
        last_d = 1'b1;
        trial(0, 24'h000100, 24'h0, 32'h0, 1'b0, 4, 2, 1'b0, 1'b0, 2, 32'hDEADBEEF);
        trial(2, 24'h800001, 24'h000200, 32'hA5A5A5A5, 1'b0, 1, 1, 1'b0, 1'b0, 1, 32'h11112222);
        trial(2, 24'hFFFFFF, 24'h000300, 32'h0BADF00D, 1'b1, 2, 2, 1'b0, 1'b0, 1, 32'h33334444);
        trial(1, 24'h0, 24'h7FFFFF, 32'h12345678, 1'b1, 3, 1, 1'b0, 1'b0, 2, 32'h55556666);
        trial(0, 24'h000400, 24'h0, 32'h0, 1'b0, 2, 1, 1'b1, 1'b0, 20, 32'h77778888);
        trial(2, 24'h000500, 24'h800600, 32'hCAFECAFE, 1'b0, 2, 2, 1'b0, 1'b1, 1, 32'h9999AAAA);
        bus.i_addr = 24'h123456;
        bus.i_start = 1'b1;
        tick();
        chk("rst_issue", bus.l2_start, 1);
        tick();
        reset = 1'b1;
        bus.l2_done = 1'b1;
        bus.l2_q = 32'hCAFEF00D;
        tick();
        all_zero("rst_mid");
        reset = 1'b0;
        tick();
        chk("rst_no_done", {bus.i_done, bus.d_done}, 0);
        chk("rst_no_start", bus.l2_start, 0);
        bus.l2_done = 1'b0;
        bus.i_start = 1'b0;
        tick();
        last_d = 1'b1;
        trial(2, 24'h000700, 24'h000800, 32'h01020304, 1'b1, 1, 1, 1'b0, 1'b0, 1, 32'hBEEFBEEF);
        for (int t = 0; t < 40; t++) begin
            int lat;
            lat = int'($urandom_range(0, 4));
            trial(int'($urandom_range(0, 2)), 24'($urandom), 24'($urandom), $urandom,
                  1'($urandom_range(0, 1)), lat, int'($urandom_range(1, 2)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) & (lat > 0),
                  int'($urandom_range(0, 3)), $urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
